// File: rtl/audio_pkg.sv
// Shared defaults and types for the I2S audio transmit path.
package audio_pkg;

  localparam int unsigned SampleWidthDefault = 16;
  localparam int unsigned SlotBitsDefault    = 32;

  typedef struct packed {
    logic [SampleWidthDefault-1:0] left;
    logic [SampleWidthDefault-1:0] right;
  } stereo_pair_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous FIFO holding stereo sample pairs; count is registered so that
// full/empty/level are glitch-free register decodes.
module audio_sample_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = PtrW + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [LevelW-1:0] count_q;
  logic [LevelW-1:0] count_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == LevelW'(DEPTH));
  assign empty   = (count_q == '0);
  // A pop while full does not free a slot for a push in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + LevelW'(1);
      2'b01:   count_d = count_q - LevelW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter running on the audio master clock: FIFO-buffered stereo
// pairs are serialised MSB first with a one-bit delay after each word-clock edge.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH  = SampleWidthDefault,
  parameter int unsigned SLOT_BITS     = SlotBitsDefault,
  parameter int unsigned MCLK_PER_SCLK = 4,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic [SAMPLE_WIDTH-1:0]     sample_left,
  input  logic [SAMPLE_WIDTH-1:0]     sample_right,
  output logic                        audio_sclk,
  output logic                        audio_lrck,
  output logic                        audio_dac,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned FrameBits = 2 * SLOT_BITS;
  localparam int unsigned DivW      = (MCLK_PER_SCLK > 1) ? $clog2(MCLK_PER_SCLK) : 1;
  localparam int unsigned PosW      = $clog2(FrameBits);

  logic [DivW-1:0]         div_q, div_d;
  logic [PosW-1:0]         bit_pos_q, bit_pos_d;
  logic                    sclk_q, sclk_d;
  logic                    lrck_q, lrck_d;
  logic                    dac_q, dac_d;
  logic                    underrun_q, underrun_d;
  logic [SAMPLE_WIDTH-1:0] left_sr_q, left_sr_d;
  logic [SAMPLE_WIDTH-1:0] right_sr_q, right_sr_d;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic [2*SAMPLE_WIDTH-1:0] fifo_rdata;

  logic            sclk_rise;
  logic            fall_event;
  logic            frame_load;
  logic [PosW-1:0] pos_next;
  logic            slot_right;
  logic [PosW-1:0] slot_pos;
  logic            data_slot;

  audio_sample_fifo #(
    .WIDTH(2 * SAMPLE_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (sample_valid),
    .pop  (frame_load),
    .wdata({sample_left, sample_right}),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );

  assign sample_ready = !fifo_full;

  assign sclk_rise  = (div_q == DivW'(MCLK_PER_SCLK / 2 - 1));
  assign fall_event = (div_q == DivW'(MCLK_PER_SCLK - 1));
  assign pos_next   = (bit_pos_q == PosW'(FrameBits - 1)) ? '0 : bit_pos_q + PosW'(1);
  assign frame_load = fall_event && (bit_pos_q == PosW'(FrameBits - 1));
  assign slot_right = (pos_next >= PosW'(SLOT_BITS));
  assign slot_pos   = slot_right ? pos_next - PosW'(SLOT_BITS) : pos_next;
  // Slot position 0 is the I2S delay bit; data occupies positions 1..SAMPLE_WIDTH.
  assign data_slot  = (slot_pos != '0) && (slot_pos <= PosW'(SAMPLE_WIDTH));

  always_comb begin
    div_d      = fall_event ? '0 : div_q + DivW'(1);
    bit_pos_d  = bit_pos_q;
    sclk_d     = sclk_q;
    lrck_d     = lrck_q;
    dac_d      = dac_q;
    underrun_d = 1'b0;
    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;

    if (sclk_rise) sclk_d = 1'b1;

    if (fall_event) begin
      sclk_d    = 1'b0;
      bit_pos_d = pos_next;
      lrck_d    = slot_right;
      dac_d     = 1'b0;
      if (frame_load) begin
        underrun_d = fifo_empty;
        if (fifo_empty) begin
          left_sr_d  = '0;
          right_sr_d = '0;
        end else begin
          left_sr_d  = fifo_rdata[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
          right_sr_d = fifo_rdata[SAMPLE_WIDTH-1:0];
        end
      end else if (data_slot) begin
        if (slot_right) begin
          dac_d      = right_sr_q[SAMPLE_WIDTH-1];
          right_sr_d = right_sr_q << 1;
        end else begin
          dac_d     = left_sr_q[SAMPLE_WIDTH-1];
          left_sr_d = left_sr_q << 1;
        end
      end
    end
  end

  // Reset parks on the last right-slot bit so the first fall event starts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      bit_pos_q  <= PosW'(FrameBits - 1);
      sclk_q     <= 1'b0;
      lrck_q     <= 1'b1;
      dac_q      <= 1'b0;
      underrun_q <= 1'b0;
      left_sr_q  <= '0;
      right_sr_q <= '0;
    end else begin
      div_q      <= div_d;
      bit_pos_q  <= bit_pos_d;
      sclk_q     <= sclk_d;
      lrck_q     <= lrck_d;
      dac_q      <= dac_d;
      underrun_q <= underrun_d;
      left_sr_q  <= left_sr_d;
      right_sr_q <= right_sr_d;
    end
  end

  assign audio_sclk = sclk_q;
  assign audio_lrck = lrck_q;
  assign audio_dac  = dac_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: cycle-count based reference model plus directed literal checks.
module tb_audio_i2s_tx;
  import audio_pkg::*;

  localparam int W = SampleWidthDefault;
  localparam int S = SlotBitsDefault;
  localparam int M = 4;
  localparam int D = 4;
  localparam int FrameClk = 2 * S * M;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic [W-1:0] sample_left = '0;
  logic [W-1:0] sample_right = '0;
  logic         audio_sclk, audio_lrck, audio_dac, underrun;
  logic [2:0]   fifo_level;

  audio_i2s_tx #(
    .SAMPLE_WIDTH (W),
    .SLOT_BITS    (S),
    .MCLK_PER_SCLK(M),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_left (sample_left),
    .sample_right(sample_right),
    .audio_sclk  (audio_sclk),
    .audio_lrck  (audio_lrck),
    .audio_dac   (audio_dac),
    .underrun    (underrun),
    .fifo_level  (fifo_level)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int und_cnt = 0;

  // Model state: m_c counts clock edges since the last reset edge.
  stereo_pair_t m_q[$];
  stereo_pair_t m_cur = '0;
  int           m_c = 0;
  bit           m_und = 0;
  bit           m_ready = 0;
  bit           m_init = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s @%0t: wait bound expired", name, $time);
  endtask

  function automatic int m_bitpos();
    if (m_c / M == 0) return 2 * S - 1;
    return (m_c / M - 1) % (2 * S);
  endfunction

  // Outputs follow directly from elapsed cycles and the pair loaded at the last frame start.
  task automatic exp_out(output logic e_sclk, output logic e_lrck, output logic e_dac);
    int ph, bp, p;
    logic [W-1:0] s;
    if (m_c == 0) begin
      e_sclk = 0; e_lrck = 1; e_dac = 0;
      return;
    end
    ph = (m_c - 1) % M;
    e_sclk = (ph >= M / 2 - 1) && (ph <= M - 2);
    bp = m_bitpos();
    e_lrck = (bp >= S);
    p = bp % S;
    s = e_lrck ? m_cur.right : m_cur.left;
    e_dac = (m_c / M > 0 && p >= 1 && p <= W) ? s[W-p] : 1'b0;
  endtask

  initial forever begin
    stereo_pair_t nw;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_c = 0;
      m_cur = '0;
      m_und = 0;
      m_init = 1;
    end else begin
      m_c++;
      m_und = 0;
      if (m_c % M == 0 && ((m_c / M) - 1) % (2 * S) == 0) begin
        if (m_q.size() > 0) m_cur = m_q.pop_front();
        else begin
          m_cur = '0;
          m_und = 1;
        end
      end
      if (sample_valid && m_ready) begin
        nw.left = sample_left;
        nw.right = sample_right;
        m_q.push_back(nw);
      end
    end
    m_ready = (m_q.size() < D);
  end

  initial forever begin
    logic e_sclk, e_lrck, e_dac;
    @(negedge clk);
    if (underrun === 1'b1) und_cnt++;
    if (m_init) begin
      exp_out(e_sclk, e_lrck, e_dac);
      check("sclk", audio_sclk, e_sclk);
      check("lrck", audio_lrck, e_lrck);
      check("dac", audio_dac, e_dac);
      check("underrun", underrun, m_und);
      check("sample_ready", sample_ready, m_ready);
      check("fifo_level", fifo_level, m_q.size());
    end
  end

  task automatic wait_sclk_rise();
    int k = 0;
    do begin @(negedge clk); k++; end while (audio_sclk !== 1'b0 && k < 20);
    do begin @(negedge clk); k++; end while (audio_sclk !== 1'b1 && k < 40);
    if (audio_sclk !== 1'b1) timeout_fail("sclk_rise");
  endtask

  task automatic wait_lrck_fall();
    logic prev;
    for (int k = 0; k < 2 * FrameClk; k++) begin
      prev = audio_lrck;
      @(negedge clk);
      if (prev === 1'b1 && audio_lrck === 1'b0) return;
    end
    timeout_fail("lrck_fall");
  endtask

  // Leaves us at the negedge just before a frame-load clock edge.
  task automatic wait_before_load();
    for (int k = 0; k < 2 * FrameClk; k++) begin
      @(negedge clk);
      if ((m_c + 1) % FrameClk == M) return;
    end
    timeout_fail("before_load");
  endtask

  initial begin
    logic [63:0] bits, lrs;
    bit found;

    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_sclk", audio_sclk, 1'b0);
    check("rst_lrck", audio_lrck, 1'b1);
    check("rst_dac", audio_dac, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ready", sample_ready, 1'b1);
    check("rst_level", fifo_level, 3'd0);

    // Single pair carried by the first frame.
    rst = 0;
    und_cnt = 0;
    sample_valid = 1;
    sample_left = 16'hA5F0;
    sample_right = 16'h0F5A;
    @(negedge clk);
    sample_valid = 0;
    wait_lrck_fall();
    for (int i = 0; i < 64; i++) begin
      wait_sclk_rise();
      bits[63-i] = audio_dac;
      lrs[63-i] = audio_lrck;
    end
    check("left_slot", bits[63:32], {1'b0, 16'hA5F0, 15'd0});
    check("right_slot", bits[31:0], {1'b0, 16'h0F5A, 15'd0});
    check("lrck_slots", lrs, {32'h0, 32'hFFFF_FFFF});
    check("first_frame_underruns", und_cnt, 0);

    // Fill with incrementing data.
    for (int i = 0; i < 12; i++) begin
      sample_valid = 1;
      sample_left = 16'h1000 + 16'(i);
      sample_right = 16'h2000 + 16'(i);
      @(negedge clk);
    end
    sample_valid = 0;
    check("full_level", fifo_level, 3'd4);
    check("full_ready", sample_ready, 1'b0);

    wait_before_load();
    @(negedge clk);
    check("pop_level", fifo_level, 3'd3);
    check("pop_ready", sample_ready, 1'b1);
    wait_before_load();
    @(negedge clk);

    // Push coincident with a frame-load pop at level 2.
    wait_before_load();
    sample_valid = 1;
    sample_left = 16'hBEEF;
    sample_right = 16'hCAFE;
    @(negedge clk);
    sample_valid = 0;
    check("pushpop_level", fifo_level, 3'd2);

    // Drain to empty; third load underruns.
    repeat (2) begin
      wait_before_load();
      @(negedge clk);
    end
    wait_before_load();
    @(negedge clk);
    check("drain_underrun", underrun, 1'b1);
    check("drain_lrck", audio_lrck, 1'b0);
    check("drain_level", fifo_level, 3'd0);
    @(negedge clk);
    check("drain_underrun_single", underrun, 1'b0);

    // Reset mid-frame with three pairs queued.
    wait_before_load();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1;
      sample_left = 16'h7000 + 16'(i);
      sample_right = 16'h8000 + 16'(i);
      @(negedge clk);
    end
    sample_valid = 0;
    check("pre_rst_level", fifo_level, 3'd3);
    found = 0;
    for (int k = 0; k < FrameClk && !found; k++) begin
      if (m_bitpos() == 8 && audio_lrck === 1'b0) found = 1;
      else @(negedge clk);
    end
    if (!found) timeout_fail("bit8");
    rst = 1;
    @(negedge clk);
    check("midrst_level", fifo_level, 3'd0);
    check("midrst_lrck", audio_lrck, 1'b1);
    check("midrst_sclk", audio_sclk, 1'b0);
    check("midrst_dac", audio_dac, 1'b0);
    rst = 0;
    wait_lrck_fall();
    check("post_rst_underrun", underrun, 1'b1);

    // Randomized traffic: busy phase, then sparse phase that starves the FIFO.
    for (int i = 0; i < 4000; i++) begin
      sample_valid = (i < 2000) ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 999) < 3);
      sample_left = W'($urandom);
      sample_right = W'($urandom);
      @(negedge clk);
    end
    sample_valid = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Audio serializer driven from the 12.288 MHz audio PLL output (outclk_0), i.e. the consumer of the audio clock.
- Accepts stereo PCM sample pairs through a valid/ready handshake into a small FIFO.
- Emits a Philips I2S stream to the DAC: bit clock, word clock and serial data, at 48 kHz with a 64-SCLK frame.
- All logic runs in the MCLK domain. Producers in other domains cross through their own synchronizers upstream.

Parameters:
- SAMPLE_WIDTH, 16: bits per channel sample; must be ≤ SLOT_BITS-1.
- SLOT_BITS, 32: SCLK periods per channel slot; frame is 2*SLOT_BITS.
- MCLK_PER_SCLK, 4: clk cycles per SCLK period; even, ≥2.
- FIFO_DEPTH, 4: sample-pair entries; power of two, ≥2.

Ports:
- clk  in  1: audio master clock, 12.288 MHz from PLL outclk_0.
- rst  in  1: synchronous, active-high reset. Drive it from the inverse of PLL locked, synchronized to clk.
- sample_valid  in  1: producer offers a pair.
- sample_ready  out  1: FIFO can accept; equals !full.
- sample_left  in  SAMPLE_WIDTH: left sample, two's complement.
- sample_right  in  SAMPLE_WIDTH: right sample, two's complement.
- audio_sclk  out  1: bit clock, clk/MCLK_PER_SCLK.
- audio_lrck  out  1: word clock; 0 = left slot, 1 = right slot.
- audio_dac  out  1: serial data, MSB first.
- underrun  out  1: one-cycle pulse when a frame starts with the FIFO empty.
- fifo_level  out  clog2(FIFO_DEPTH)+1: current occupancy.

Behaviour:
- Reset values:
  - div=0, audio_sclk=0, audio_dac=0, underrun=0.
  - bit_pos=2*SLOT_BITS-1 and audio_lrck=1 (the last right bit).
  - FIFO empty, fifo_level=0, sample_ready=1.
  - Reset mid-frame aborts the frame and discards FIFO contents. No partial word is emitted after reset.
- Divider:
  - div counts 0..MCLK_PER_SCLK-1 and wraps.
  - At div==MCLK_PER_SCLK/2-1, audio_sclk<=1 (rising edge).
  - At div==MCLK_PER_SCLK-1 a "fall event" occurs: audio_sclk<=0, and audio_lrck and audio_dac update on the same clk edge.
  - Data therefore changes on the SCLK falling edge and is stable across the rising edge.
- Bit position:
  - bit_pos (0..2*SLOT_BITS-1) advances by 1 on every fall event and wraps to 0.
  - audio_lrck <= (next bit_pos ≥ SLOT_BITS).
- Slot format (I2S one-bit delay), with p = next bit_pos mod SLOT_BITS:
  - For p in 1..SAMPLE_WIDTH, audio_dac <= sample bit [SAMPLE_WIDTH-p].
  - For all other p, audio_dac <= 0.
  - The left sample drives the left slot and the right sample drives the right slot.
- Frame load: on the fall event where bit_pos wraps to 0:
  - If the FIFO is non-empty, pop the head pair into the shift/hold registers.
  - If it is empty, load zeros and pulse underrun for exactly that cycle.
  - The first fall event after reset (at clk cycle MCLK_PER_SCLK-1) is a frame load.
- FIFO:
  - Push when sample_valid && sample_ready.
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - While full, sample_ready=0, so no push occurs even if a pop happens that cycle. sample_ready rises on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - sample_ready and fifo_level are registered.
- Latency: a pair pushed at least one cycle before a frame-load event is output in that frame. The left MSB appears one SCLK after the lrck falling edge.
- Rates at defaults:
  - SCLK period = 4 clk (3.072 MHz).
  - LRCK period = 256 clk (48 kHz).
  - One pop per 256 clk.

Decomposition:
- Package audio_pkg: SAMPLE_WIDTH and SLOT_BITS defaults, and a packed stereo-pair struct (left, right).
- Sub-module audio_sample_fifo (synchronous, registered count, push/pop/full/empty/level) holds the pairs.
- The serializer, divider and bit counter stay in audio_i2s_tx.

Test Plan:
- Reset then idle 512 clk -> outputs hold reset values until cycle 3, then audio_sclk toggles with period 4 clk and audio_lrck with period 256 clk. Underrun pulses at each frame start (cycles 3, 259). audio_dac stays 0.
- Push one pair L=16'hA5F0, R=16'h0F5A at cycle 1 -> the frame starting at cycle 3 carries it. Sampled on SCLK rising edges:
  - lrck=0 slot: 0, then 1010010111110000, then 15 zeros.
  - lrck=1 slot: 0, then 0000111101011010, then 15 zeros.
  - underrun stays 0 for that frame.
- Hold sample_valid=1 with incrementing data -> 4 pairs accepted, sample_ready=0 with fifo_level=4. At each frame load fifo_level drops to 3 and sample_ready returns to 1 for one acceptance. Frames carry the pairs in push order.
- Push a pair in the same cycle as a frame-load pop with the FIFO at level 2 -> level stays 2, and the popped pair is the older entry.
- FIFO drains to empty -> the next frame outputs all zeros and underrun is a single-cycle pulse aligned to the lrck falling edge.
- Assert rst at left slot bit 8 with 3 entries queued -> the next cycle shows reset values and fifo_level=0. After release, the first frame is all zeros and underrun pulses.
